// File: rtl/fpnew_cast_writeback.sv
// Writeback buffer for the FP-to-FP cast unit: NaN-boxes each result to the register-file width,
// queues it in a small circular FIFO behind a valid/ready handshake and accumulates popped fflags.
package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:          return 32;
      FP64:          return 64;
      FP16, FP16ALT: return 16;
      FP8:           return 8;
      default:       return 32;
    endcase
  endfunction
endpackage

module fpnew_cast_writeback #(
  parameter fpnew_pkg::fp_format_e DstFpFormat = fpnew_pkg::FP32,
  parameter int unsigned           Width       = 64,
  parameter int unsigned           Depth       = 2,
  parameter type                   TagType     = logic,
  localparam int unsigned          DST_WIDTH   = fpnew_pkg::fp_width(DstFpFormat)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DST_WIDTH-1:0] result_i,
  input  fpnew_pkg::status_t   status_i,
  input  logic                 extension_bit_i,
  input  TagType               tag_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [Width-1:0]     result_o,
  output fpnew_pkg::status_t   status_o,
  output TagType               tag_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 fflags_clear_i,
  output logic [4:0]           fflags_o,
  output logic                 busy_o
);

  localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CNT_W = $clog2(Depth + 1);

  if (Width < DST_WIDTH) begin : g_width_check
    $error("fpnew_cast_writeback: Width must be >= the destination format width");
  end
  if (Depth < 1) begin : g_depth_check
    $error("fpnew_cast_writeback: Depth must be >= 1");
  end

  // Upper bits are all-ones for a NaN-boxed result and all-zeros otherwise.
  function automatic logic [Width-1:0] nan_box(input logic [DST_WIDTH-1:0] value,
                                               input logic                 ext);
    logic [Width-1:0] boxed;
    boxed                = {Width{ext}};
    boxed[DST_WIDTH-1:0] = value;
    return boxed;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(Depth - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  logic [Width-1:0]   mem_result [Depth];
  fpnew_pkg::status_t mem_status [Depth];
  TagType             mem_tag    [Depth];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [4:0]       fflags_q;

  logic       push;
  logic       pop;
  logic [4:0] head_flags;

  // Readiness depends only on stored occupancy, so a full FIFO never accepts in a popping cycle.
  assign in_ready_o  = (count_q != CNT_W'(Depth));
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;

  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  assign result_o   = mem_result[rd_ptr_q];
  assign status_o   = mem_status[rd_ptr_q];
  assign tag_o      = mem_tag[rd_ptr_q];
  assign head_flags = mem_status[rd_ptr_q];
  assign fflags_o   = fflags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_result[i] <= '0;
        mem_status[i] <= '0;
        mem_tag[i]    <= '0;
      end
    end else begin
      // A clear and a pop in the same cycle keep the popped flags; flushed entries never count.
      fflags_q <= (fflags_clear_i ? 5'd0 : fflags_q) | (pop ? head_flags : 5'd0);
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          mem_result[wr_ptr_q] <= nan_box(result_i, extension_bit_i);
          mem_status[wr_ptr_q] <= status_i;
          mem_tag[wr_ptr_q]    <= tag_i;
          wr_ptr_q             <= ptr_next(wr_ptr_q);
        end
        if (pop) begin
          rd_ptr_q <= ptr_next(rd_ptr_q);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpnew_cast_writeback.sv
// Bench for fpnew_cast_writeback: FP16 results boxed to 64 bits, queue-based reference model
// compared every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fpnew_cast_writeback;
  localparam int D  = 2;
  typedef logic [3:0] tag_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance, Depth 2
  logic [15:0] result_i = '0;
  logic [4:0]  status_i = '0;
  logic        ext_i = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, clr = 1'b0;
  tag_t        tag_i = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] result_o;
  logic [4:0]  status_o, fflags_o;
  tag_t        tag_o;

  fpnew_cast_writeback #(
    .DstFpFormat(fpnew_pkg::FP16), .Width(64), .Depth(D), .TagType(tag_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .result_i(result_i), .status_i(status_i),
    .extension_bit_i(ext_i), .tag_i(tag_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .fflags_clear_i(clr),
    .fflags_o(fflags_o), .busy_o(busy)
  );

  // Second instance, Depth 3, for non-power-of-two wrap
  logic [15:0] r3 = '0;
  logic        v3 = 1'b0, ordy3 = 1'b0;
  tag_t        t3 = '0;
  logic        in_ready3, out_valid3, busy3;
  logic [63:0] result_o3;
  logic [4:0]  status_o3, fflags_o3;
  tag_t        tag_o3;

  fpnew_cast_writeback #(
    .DstFpFormat(fpnew_pkg::FP16), .Width(64), .Depth(3), .TagType(tag_t)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .result_i(r3), .status_i(5'd0),
    .extension_bit_i(1'b0), .tag_i(t3), .in_valid_i(v3), .in_ready_o(in_ready3),
    .flush_i(1'b0), .result_o(result_o3), .status_o(status_o3), .tag_o(tag_o3),
    .out_valid_o(out_valid3), .out_ready_i(ordy3), .fflags_clear_i(1'b0),
    .fflags_o(fflags_o3), .busy_o(busy3)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of boxed entries plus the sticky flag word.
  typedef struct {
    logic [63:0] r;
    logic [4:0]  s;
    tag_t        t;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_ff = '0;
  bit         last_push = 0;
  bit         m_push, m_pop;

  always @(negedge rst_n) begin
    mq.delete();
    m_ff = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_push = in_valid && (mq.size() != D) && !flush;
      m_pop  = (mq.size() != 0) && out_ready && !flush;
      m_ff   = (clr ? 5'd0 : m_ff) | (m_pop ? mq[0].s : 5'd0);
      if (flush) mq.delete();
      else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back('{r: {ext_i ? 48'hFFFF_FFFF_FFFF : 48'h0, result_i},
                                   s: status_i, t: tag_i});
      end
      last_push = m_push;
    end
    #1;
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("busy", 64'(busy), 64'(mq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() != D));
      chk("fflags", 64'(fflags_o), 64'(m_ff));
      if (mq.size() != 0) begin
        chk("head_result", result_o, mq[0].r);
        chk("head_status", 64'(status_o), 64'(mq[0].s));
        chk("head_tag", 64'(tag_o), 64'(mq[0].t));
      end
    end
  end

  task automatic offer(input logic [15:0] r, input logic [4:0] s, input logic e, input tag_t t);
    in_valid = 1'b1;
    result_i = r;
    status_i = s;
    ext_i    = e;
    tag_i    = t;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", result_o, 64'd0);
    chk("rst_fflags", 64'(fflags_o), 64'd0);
    chk("rst_status", 64'(status_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    rst_n = 1'b1;

    // Boxing and one-cycle latency
    @(negedge clk); out_ready = 1'b1; offer(16'h3C00, 5'h00, 1'b1, 4'd1);
    @(negedge clk);
    chk("t1_box1", result_o, 64'hFFFF_FFFF_FFFF_3C00);
    chk("t1_vld1", 64'(out_valid), 64'd1);
    offer(16'hBC00, 5'h00, 1'b0, 4'd2);
    @(negedge clk);
    chk("t1_box0", result_o, 64'h0000_0000_0000_BC00);
    chk("t1_tag2", 64'(tag_o), 64'd2);
    in_valid = 1'b0;
    @(negedge clk); chk("t1_empty", 64'(out_valid), 64'd0);

    // Full FIFO backpressure
    out_ready = 1'b0; offer(16'h1111, 5'h00, 1'b1, 4'd3);
    @(negedge clk); offer(16'h2222, 5'h00, 1'b0, 4'd4);
    @(negedge clk); chk("t2_full1", 64'(in_ready), 64'd0); offer(16'h3333, 5'h00, 1'b1, 4'd5);
    @(negedge clk);
    chk("t2_full2", 64'(in_ready), 64'd0);
    chk("t2_headA", result_o, 64'hFFFF_FFFF_FFFF_1111);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_headB", result_o, 64'h0000_0000_0000_2222);
    chk("t2_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk); chk("t2_headC", result_o, 64'hFFFF_FFFF_FFFF_3333); in_valid = 1'b0;
    @(negedge clk); chk("t2_empty", 64'(out_valid), 64'd0);

    // Sticky flags and clear-with-pop
    offer(16'h0001, 5'h01, 1'b0, 4'd6);
    @(negedge clk); offer(16'h0002, 5'h05, 1'b0, 4'd7);
    @(negedge clk); chk("t3_ff01", 64'(fflags_o), 64'h01); offer(16'h0003, 5'h02, 1'b0, 4'd8);
    @(negedge clk); chk("t3_ff05", 64'(fflags_o), 64'h05); in_valid = 1'b0; clr = 1'b1;
    @(negedge clk); chk("t3_ff02", 64'(fflags_o), 64'h02); clr = 1'b0;

    // Flush with two queued entries and a simultaneous push attempt
    out_ready = 1'b0; offer(16'h00AA, 5'h10, 1'b1, 4'd9);
    @(negedge clk); offer(16'h00BB, 5'h08, 1'b1, 4'd10);
    @(negedge clk);
    chk("t4_full", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1; offer(16'h00CC, 5'h04, 1'b1, 4'd11);
    @(negedge clk);
    chk("t4_vld", 64'(out_valid), 64'd0);
    chk("t4_rdy", 64'(in_ready), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_ff", 64'(fflags_o), 64'h02);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("t4_not_stored", 64'(out_valid), 64'd0);

    // Stall stability
    out_ready = 1'b0; offer(16'h4200, 5'h04, 1'b1, 4'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) offer(16'h1234, 5'h00, 1'b0, 4'd6);
      if (i == 1) in_valid = 1'b0;
      chk("t5_result", result_o, 64'hFFFF_FFFF_FFFF_4200);
      chk("t5_status", 64'(status_o), 64'h04);
      chk("t5_tag", 64'(tag_o), 64'd5);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset with entries queued and all flags set
    offer(16'h0000, 5'h1F, 1'b0, 4'd0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); chk("t6_ff1f", 64'(fflags_o), 64'h1F);
    out_ready = 1'b0; offer(16'hAAAA, 5'h00, 1'b1, 4'd1);
    @(negedge clk); offer(16'hBBBB, 5'h00, 1'b1, 4'd2);
    @(negedge clk); in_valid = 1'b0; chk("t6_two_queued", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", 64'(out_valid), 64'd0);
    chk("t6_rdy", 64'(in_ready), 64'd1);
    chk("t6_ff", 64'(fflags_o), 64'd0);
    chk("t6_result", result_o, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Depth-3 wrap: seven single-entry passes, then fill to three and drain
    ordy3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("t7_tag", 64'(tag_o3), 64'(k - 1));
        chk("t7_res", result_o3, 64'(16'h0100 + k - 1));
      end
      v3 = 1'b1; t3 = tag_t'(k); r3 = 16'(16'h0100 + k);
    end
    @(negedge clk); chk("t7_tag6", 64'(tag_o3), 64'd6); v3 = 1'b0;
    @(negedge clk); chk("t7_empty", 64'(out_valid3), 64'd0);
    ordy3 = 1'b0;
    for (int k = 7; k < 10; k++) begin
      v3 = 1'b1; t3 = tag_t'(k); r3 = 16'(k);
      @(negedge clk);
    end
    v3 = 1'b0;
    chk("t7_full3", 64'(in_ready3), 64'd0);
    chk("t7_h7", 64'(tag_o3), 64'd7);
    ordy3 = 1'b1;
    @(negedge clk); chk("t7_h8", 64'(tag_o3), 64'd8);
    @(negedge clk); chk("t7_h9", 64'(tag_o3), 64'd9);
    @(negedge clk); chk("t7_drained", 64'(out_valid3), 64'd0);

    // Randomized traffic; in_* held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 3) != 0);
        result_i = 16'($urandom);
        status_i = 5'($urandom);
        ext_i    = 1'($urandom);
        tag_i    = tag_t'($urandom);
      end
      out_ready = (c < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      clr       = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("final_drained", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
